// File: rtl/uart_cmd_decoder.sv
// UART ASCII command decoder: RX FIFO bytes -> one-cycle stopwatch control pulses.
// Optional echo of accepted bytes to the TX FIFO when UART_CMD_ECHO_EN is defined.
module uart_cmd_decoder #(
  parameter logic [7:0] CMD_RUN   = 8'h52,
  parameter logic [7:0] CMD_CLEAR = 8'h43,
  parameter logic [7:0] CMD_MODE  = 8'h4D,
  parameter bit         CASE_FOLD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_pop,
  output logic [7:0] tx_data,
  input  logic       tx_full,
  output logic       tx_push,
  output logic       uart_enable,
  output logic       uart_clear,
  output logic       uart_mode,
  output logic       cmd_err,
  output logic [7:0] cmd_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
`ifdef UART_CMD_ECHO_EN
  localparam logic [1:0] S_ECHO   = 2'd2;
`endif

  logic [1:0] r_state;
  logic [7:0] r_cmd;
  logic       r_rx_pop;
  logic       r_enable;
  logic       r_clear;
  logic       r_mode;
  logic       r_err;
  logic [7:0] r_cnt;

  logic [7:0] w_key;
  logic       w_run;
  logic       w_clr;
  logic       w_mode;
  logic       w_ign;
  logic       w_acc;

  // Clearing bit 5 folds ASCII lowercase onto uppercase
  assign w_key  = CASE_FOLD ? (r_cmd & 8'hDF) : r_cmd;
  assign w_run  = (w_key == CMD_RUN);
  assign w_clr  = (w_key == CMD_CLEAR);
  assign w_mode = (w_key == CMD_MODE);
  assign w_ign  = (r_cmd == 8'h0D) || (r_cmd == 8'h0A);
  assign w_acc  = w_run || w_clr || w_mode;

`ifdef UART_CMD_ECHO_EN
  logic       r_tx_push;
  logic [7:0] r_tx_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cmd    <= 8'h00;
      r_rx_pop <= 1'b0;
      r_enable <= 1'b0;
      r_clear  <= 1'b0;
      r_mode   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 8'h00;
`ifdef UART_CMD_ECHO_EN
      r_tx_push <= 1'b0;
      r_tx_data <= 8'h00;
`endif
    end else begin
      r_rx_pop <= 1'b0;
      r_enable <= 1'b0;
      r_clear  <= 1'b0;
      r_mode   <= 1'b0;
      r_err    <= 1'b0;
`ifdef UART_CMD_ECHO_EN
      r_tx_push <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!rx_empty) begin
            r_cmd    <= rx_data;
            r_rx_pop <= 1'b1;
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            w_run: begin
              r_enable <= 1'b1;
              r_cnt    <= r_cnt + 8'd1;
            end
            w_clr: begin
              r_clear <= 1'b1;
              r_cnt   <= r_cnt + 8'd1;
            end
            w_mode: begin
              r_mode <= 1'b1;
              r_cnt  <= r_cnt + 8'd1;
            end
            w_ign: begin
            end
            default: r_err <= 1'b1;
          endcase
`ifdef UART_CMD_ECHO_EN
          r_state <= w_acc ? S_ECHO : S_IDLE;
`else
          r_state <= S_IDLE;
`endif
        end
`ifdef UART_CMD_ECHO_EN
        // Backpressure: hold here (no pops) until TX has room
        S_ECHO: begin
          if (!tx_full) begin
            r_tx_data <= r_cmd;
            r_tx_push <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_CMD_ECHO_EN
  assign tx_push = r_tx_push;
  assign tx_data = r_tx_data;
`else
  logic w_unused;
  assign w_unused = tx_full ^ w_acc;
  assign tx_push  = 1'b0;
  assign tx_data  = 8'h00;
`endif

  assign rx_pop      = r_rx_pop;
  assign uart_enable = r_enable;
  assign uart_clear  = r_clear;
  assign uart_mode   = r_mode;
  assign cmd_err     = r_err;
  assign cmd_cnt     = r_cnt;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder (FWFT RX FIFO model,
// plus a second instance built with CASE_FOLD=0).
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       tx_push;
  logic       uart_enable;
  logic       uart_clear;
  logic       uart_mode;
  logic       cmd_err;
  logic [7:0] cmd_cnt;

  logic [7:0] nf_rx_data;
  logic       nf_rx_empty;
  logic       nf_rx_pop;
  logic [7:0] nf_tx_data;
  logic       nf_tx_push;
  logic       nf_enable;
  logic       nf_clear;
  logic       nf_mode;
  logic       nf_err;
  logic [7:0] nf_cnt;

  int checks = 0;
  int failures = 0;

  int n_pop, n_en, n_clr, n_mode, n_err, n_push, n_multi;
  logic saw_ff;
  logic [7:0] q[$];

  uart_cmd_decoder u_dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
    .tx_data(tx_data), .tx_full(tx_full), .tx_push(tx_push),
    .uart_enable(uart_enable), .uart_clear(uart_clear),
    .uart_mode(uart_mode), .cmd_err(cmd_err), .cmd_cnt(cmd_cnt)
  );

  uart_cmd_decoder #(.CASE_FOLD(1'b0)) u_nf (
    .clk(clk), .rst(rst),
    .rx_data(nf_rx_data), .rx_empty(nf_rx_empty), .rx_pop(nf_rx_pop),
    .tx_data(nf_tx_data), .tx_full(tx_full), .tx_push(nf_tx_push),
    .uart_enable(nf_enable), .uart_clear(nf_clear),
    .uart_mode(nf_mode), .cmd_err(nf_err), .cmd_cnt(nf_cnt)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model: pop during the strobe cycle, refresh head on negedge
  always @(negedge clk) begin
    if (rx_pop && q.size() > 0) void'(q.pop_front());
    rx_empty = (q.size() == 0);
    rx_data  = (q.size() > 0) ? q[0] : 8'h00;
  end

  always @(negedge clk) begin
    n_pop  += int'(rx_pop);
    n_en   += int'(uart_enable);
    n_clr  += int'(uart_clear);
    n_mode += int'(uart_mode);
    n_err  += int'(cmd_err);
    n_push += int'(tx_push);
    if ((int'(uart_enable) + int'(uart_clear) + int'(uart_mode) + int'(cmd_err)) > 1)
      n_multi++;
    if (cmd_cnt == 8'hFF) saw_ff = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    n_pop = 0; n_en = 0; n_clr = 0; n_mode = 0;
    n_err = 0; n_push = 0; n_multi = 0; saw_ff = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int t;

  initial begin
    clr_cnt();
    rst = 1'b1;
    tx_full = 1'b0;
    nf_rx_data = 8'h00;
    nf_rx_empty = 1'b1;
    q.push_back(8'h52);
    tick();
    tick();
    chk("rst_pop", rx_pop, 0);
    chk("rst_en", uart_enable, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_cnt", cmd_cnt, 0);
    chk("rst_txpush", tx_push, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_npop", n_pop, 0);

    // single 'R' held at the FIFO head through reset
    rst = 1'b0;
    tick();
    chk("one_pop_hi", rx_pop, 1);
    chk("one_en_early", uart_enable, 0);
    tick();
    chk("one_pop_lo", rx_pop, 0);
    chk("one_en_hi", uart_enable, 1);
    chk("one_cnt", cmd_cnt, 1);
    tick();
    chk("one_en_lo", uart_enable, 0);
    chk("one_npop", n_pop, 1);
    chk("one_nen", n_en, 1);

    // reset while a byte is in flight
    clr_cnt();
    q.push_back(8'h52);
    tick();
    tick();
    chk("mid_pop", rx_pop, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_nen", n_en, 0);
    chk("mid_npop", n_pop, 1);
    chk("mid_cnt", cmd_cnt, 0);

    // stream C, m, CR, x
    do_reset();
    clr_cnt();
    q.push_back(8'h43);
    q.push_back(8'h6D);
    q.push_back(8'h0D);
    q.push_back(8'h78);
    for (int i = 0; i < 14; i++) tick();
    chk("str_clr", n_clr, 1);
    chk("str_mode", n_mode, 1);
    chk("str_err", n_err, 1);
    chk("str_en", n_en, 0);
    chk("str_pop", n_pop, 4);
    chk("str_cnt", cmd_cnt, 2);
    chk("str_multi", n_multi, 0);
    chk("str_qempty", q.size(), 0);

    // CASE_FOLD=0 instance: 'r' rejected, 'R' accepted
    nf_rx_data = 8'h72;
    nf_rx_empty = 1'b0;
    tick();
    nf_rx_empty = 1'b1;
    chk("nf_pop", nf_rx_pop, 1);
    tick();
    chk("nf_err", nf_err, 1);
    chk("nf_en", nf_enable, 0);
    chk("nf_cnt0", nf_cnt, 0);
    nf_rx_data = 8'h52;
    nf_rx_empty = 1'b0;
    tick();
    nf_rx_empty = 1'b1;
    tick();
    chk("nf_en_R", nf_enable, 1);
    chk("nf_err_R", nf_err, 0);
    chk("nf_cnt1", nf_cnt, 1);

    // 256 'M' back to back: wrap and 2-cycle throughput
    do_reset();
    clr_cnt();
    for (int i = 0; i < 256; i++) q.push_back(8'h4D);
    t = 0;
    for (int i = 1; i <= 700; i++) begin
      tick();
      if (n_mode == 256) begin
        t = i;
        break;
      end
    end
    chk("wrap_ticks", t, 513);
    chk("wrap_nmode", n_mode, 256);
    chk("wrap_npop", n_pop, 256);
    chk("wrap_cnt", cmd_cnt, 0);
    chk("wrap_sawff", saw_ff, 1);
    chk("wrap_multi", n_multi, 0);

`ifdef UART_CMD_ECHO_EN
    // echo under backpressure
    tick();
    do_reset();
    clr_cnt();
    tx_full = 1'b1;
    q.push_back(8'h52);
    q.push_back(8'h43);
    for (int i = 0; i < 6; i++) tick();
    chk("echo_en", n_en, 1);
    chk("echo_nopush", n_push, 0);
    chk("echo_onepop", n_pop, 1);
    tx_full = 1'b0;
    tick();
    chk("echo_push", tx_push, 1);
    chk("echo_data", tx_data, 8'h52);
    tick();
    chk("echo_push_lo", tx_push, 0);
    chk("echo_next_pop", rx_pop, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("echo_npush", n_push, 2);
`else
    chk("noecho_push", n_push, 0);
    chk("noecho_data", tx_data, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Consumes received bytes from the UART RX FIFO and decodes ASCII commands into one-cycle control pulses for the stopwatch segment block: uart_enable (run/stop), uart_clear and uart_mode.
- Sits between uart_top's RX FIFO read side and the segment block's uart_* inputs.
- Reports unrecognised bytes and counts accepted commands.
- Can optionally echo each accepted byte back through the TX FIFO.

Parameters:
- CMD_RUN, 8'h52 ('R'): byte that pulses uart_enable.
- CMD_CLEAR, 8'h43 ('C'): byte that pulses uart_clear.
- CMD_MODE, 8'h4D ('M'): byte that pulses uart_mode.
- CASE_FOLD, 1: when 1, the lowercase form (byte | 8'h20) is also accepted. All CMD_* must be uppercase ASCII letters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  RX FIFO head byte (first-word fall-through; valid while rx_empty=0)
- rx_empty  in  1  RX FIFO empty
- rx_pop  out  1  one-cycle RX FIFO read strobe
- tx_data  out  8  byte to TX FIFO
- tx_full  in  1  TX FIFO full
- tx_push  out  1  one-cycle TX FIFO write strobe
- uart_enable  out  1  run/stop toggle request, one-cycle pulse
- uart_clear  out  1  clear request, one-cycle pulse
- uart_mode  out  1  mode-toggle request, one-cycle pulse
- cmd_err  out  1  one-cycle pulse on an unrecognised byte
- cmd_cnt  out  8  count of accepted commands, wraps 255->0

Behaviour:
- All outputs are registered.
- Reset (synchronous, rst=1 at the edge):
  - state goes to IDLE.
  - rx_pop, tx_push, uart_enable, uart_clear, uart_mode, cmd_err and cmd_cnt all go to 0.
  - tx_data and the internal cmd_reg go to 8'h00.
- FSM states: IDLE, DECODE, ECHO (ECHO exists only with the optional feature).
- IDLE: if rx_empty=0 at edge N, then cmd_reg<=rx_data, rx_pop=1 during cycle N+1 (exactly one cycle), and state goes to DECODE. Otherwise stay in IDLE with rx_pop=0.
- DECODE (edge N+1): classify cmd_reg. The chosen pulse is high during cycle N+2 for exactly one cycle.
  - matches CMD_RUN -> uart_enable=1, cmd_cnt+1
  - matches CMD_CLEAR -> uart_clear=1, cmd_cnt+1
  - matches CMD_MODE -> uart_mode=1, cmd_cnt+1
  - 8'h0D or 8'h0A -> silently ignored: no pulse, no count, no error
  - anything else -> cmd_err=1, cmd_cnt unchanged
  - Next state: ECHO if the echo feature is built and the byte was accepted; otherwise IDLE.
- Matching with CASE_FOLD=1 compares (cmd_reg & 8'hDF) against CMD_*. With CASE_FOLD=0 the match must be exact, so a lowercase letter gives cmd_err.
- Latency: command pulse 2 cycles after rx_empty=0 is first sampled.
- Throughput: without echo, at most one byte per 2 cycles; back-to-back bytes produce pulses 2 cycles apart.
- At most one of uart_enable/uart_clear/uart_mode/cmd_err is high in any cycle.
- rx_pop is never asserted outside the cycle following IDLE acceptance, so there are no double pops.
- cmd_cnt wraps from 8'hFF to 8'h00 on the next accepted command.
- Reset mid-operation, from any state, abandons the in-flight byte: no pulse, no echo, no further pop.

Optional Feature:
- Macro: UART_CMD_ECHO_EN.
- When defined, ECHO state is built:
  - ECHO waits while tx_full=1, with tx_push=0 and no RX pops (backpressure stalls decoding).
  - At the first edge with tx_full=0: tx_data<=cmd_reg, tx_push=1 for one cycle, then return to IDLE.
  - Throughput becomes at least 3 cycles per accepted byte.
  - Rejected and ignored bytes are not echoed.
- When undefined: tx_push is tied 0, tx_data is tied 8'h00, and tx_full is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles with rx_empty=0 and rx_data=8'h52 -> rx_pop=0, no pulses, cmd_cnt=0; after release, rx_pop pulses once.
- Single command: rx_data=8'h52, rx_empty=0 for 1 cycle then 1 -> rx_pop high 1 cycle, uart_enable high exactly 1 cycle 2 cycles later, cmd_cnt=1.
- Stream: FIFO holds 'C','m',8'h0D,'x' (CASE_FOLD=1) -> uart_clear pulse, uart_mode pulse, no activity for CR, cmd_err pulse; cmd_cnt=2; 4 rx_pops.
- Case fold off: CASE_FOLD=0, byte 'r' (8'h72) -> cmd_err=1, uart_enable stays 0.
- Wrap: 256 'M' bytes -> 256 uart_mode pulses, cmd_cnt ends at 8'h00.
- Echo (UART_CMD_ECHO_EN): byte 'R' with tx_full=1 held 5 cycles -> uart_enable pulses, no tx_push and no rx_pop while full; on tx_full=0, tx_push=1 with tx_data=8'h52 for one cycle, then the next byte is popped.
